// File: rtl/smi_fuzz_seq_pkg.sv
// Shared state encoding and constants for the memory fuzz test sequencer.
// Imported by smi_fuzz_seq_accum and smi_mem_lib_fuzz_test_sequencer.
package smi_fuzz_seq_pkg;

    localparam int unsigned MaxWindowsWidthDefault = 16;
    localparam logic [31:0] ErrCountSat            = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        Reset       = 3'd0,
        Idle        = 3'd1,
        IssueConfig = 3'd2,
        WaitStatus  = 3'd3,
        Report      = 3'd4
    } seqState_t;

endpackage

// File: rtl/smi_fuzz_seq_accum.sv
// Error and data-count accumulators for one fuzz sequence.
// Error sum saturates; data sum wraps modulo 2^64.
module smi_fuzz_seq_accum
    import smi_fuzz_seq_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        addEn,
    input  logic [31:0] errIn,
    input  logic [63:0] dataIn,
    output logic [31:0] errSum,
    output logic [63:0] dataSum
);

    logic [32:0] errWide;

    assign errWide = {1'b0, errSum} + {1'b0, errIn};

    // Datapath only: cleared at the start of every sequence, never by reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            errSum  <= '0;
            dataSum <= '0;
        end else if (addEn) begin
            errSum  <= errWide[32] ? ErrCountSat : errWide[31:0];
            dataSum <= dataSum + dataIn;
        end
    end

endmodule

// File: rtl/smi_mem_lib_fuzz_test_sequencer.sv
// Runs a child fuzz tester over consecutive address windows and reports the totals.
// Define SMI_FUZZ_SEQ_ABORT_ON_ERROR_EN to stop the sequence at the first window with errors.
module smi_mem_lib_fuzz_test_sequencer
    import smi_fuzz_seq_pkg::*;
#(
    parameter int unsigned WindowGapBytes  = 0,
    parameter int unsigned MaxWindowsWidth = MaxWindowsWidthDefault
) (
    input  logic                       clk,
    input  logic                       srst,
    // All handshakes: a transfer happens in a cycle with valid=1 and stop=0;
    // the sender holds its data stable while valid=1 and stop=1.
    input  logic                       cfgValid,
    input  logic [63:0]                cfgAddrBase,
    input  logic [31:0]                cfgWindowSize,
    input  logic [MaxWindowsWidth-1:0] cfgNumWindows,
    input  logic [31:0]                cfgTestsPerWindow,
    output logic                       cfgStop,
    output logic                       testCfgValid,
    output logic [63:0]                testCfgMemAddrBase,
    output logic [31:0]                testCfgMemBlockSize,
    output logic [31:0]                testCfgNumTests,
    input  logic                       testCfgStop,
    input  logic                       testStatusValid,
    input  logic [31:0]                testStatusErrorCount,
    input  logic [63:0]                testStatusDataCount,
    output logic                       testStatusStop,
    output logic                       statusValid,
    output logic [31:0]                statusErrorCount,
    output logic [63:0]                statusDataCount,
    output logic [MaxWindowsWidth-1:0] statusWindowsRun,
    output logic                       statusAborted,
    input  logic                       statusStop,
    output seqState_t                  dbgState
);

    localparam logic [63:0]                GapBytes = 64'(WindowGapBytes);
    localparam logic [MaxWindowsWidth-1:0] One      = 1;

    seqState_t                  state;
    logic [31:0]                windowSize;
    logic [31:0]                testsPerWindow;
    logic [MaxWindowsWidth-1:0] numWindows;
    logic [MaxWindowsWidth-1:0] windowIndex;
    logic [MaxWindowsWidth-1:0] nextIndex;
    logic [63:0]                curBase;
    logic                       cfgAccept;
    logic                       statusXfer;
    logic                       lastWindow;
    logic                       abortNow;

    assign cfgAccept  = (state == Idle) && cfgValid;
    assign statusXfer = (state == WaitStatus) && testStatusValid;
    assign nextIndex  = windowIndex + One;
    assign lastWindow = (nextIndex == numWindows);

`ifdef SMI_FUZZ_SEQ_ABORT_ON_ERROR_EN
    logic aborted;

    assign abortNow = (testStatusErrorCount != '0);

    always_ff @(posedge clk) begin
        if (cfgAccept) begin
            aborted <= 1'b0;
        end else if (statusXfer && abortNow) begin
            aborted <= 1'b1;
        end
    end

    assign statusAborted = aborted && (state == Report);
`else
    assign abortNow      = 1'b0;
    assign statusAborted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= Reset;
        end else begin
            case (state)
                Reset:       state <= Idle;
                Idle:        if (cfgValid) state <= (cfgNumWindows != '0) ? IssueConfig : Report;
                IssueConfig: if (!testCfgStop) state <= WaitStatus;
                WaitStatus:  if (testStatusValid) state <= (lastWindow || abortNow) ? Report : IssueConfig;
                Report:      if (!statusStop) state <= Idle;
                default:     state <= Reset;
            endcase
        end
    end

    // Window base advances by accumulation so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (cfgAccept) begin
            windowSize     <= cfgWindowSize;
            testsPerWindow <= cfgTestsPerWindow;
            numWindows     <= cfgNumWindows;
            curBase        <= cfgAddrBase;
            windowIndex    <= '0;
        end else if (statusXfer) begin
            windowIndex <= nextIndex;
            curBase     <= curBase + {32'd0, windowSize} + GapBytes;
        end
    end

    smi_fuzz_seq_accum u_accum (
        .clk     (clk),
        .clear   (cfgAccept),
        .addEn   (statusXfer),
        .errIn   (testStatusErrorCount),
        .dataIn  (testStatusDataCount),
        .errSum  (statusErrorCount),
        .dataSum (statusDataCount)
    );

    assign cfgStop             = (state != Idle);
    assign testCfgValid        = (state == IssueConfig);
    assign testCfgMemAddrBase  = curBase;
    assign testCfgMemBlockSize = windowSize;
    assign testCfgNumTests     = testsPerWindow;
    assign testStatusStop      = (state != WaitStatus);
    assign statusValid         = (state == Report);
    assign statusWindowsRun    = windowIndex;
    assign dbgState            = state;

endmodule
